// File: rtl/nios_sys_seg7_scan_ctrl.sv
// Avalon-MM seven-segment scanner: time-slices one shared segment bus across
// up to eight common-anode digits, with a dark gap between digits.
module nios_sys_seg7_scan_ctrl #(
  parameter int          NUM_DIGITS   = 4,
  parameter int          BLANK_CYCLES = 2,
  parameter logic [15:0] DIV_RESET    = 16'd5000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_n
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [2:0]  IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [15:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? 16'(BLANK_CYCLES - 1) : 16'd0;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [31:0] data_reg;
  logic [16:0] ctrl_reg;
  logic [15:0] div_reg;

  logic        wr;
  logic [31:0] data_nxt;
  logic [16:0] ctrl_nxt;
  logic [15:0] div_nxt;
  logic [2:0]  idx_step;
  logic [15:0] show_load;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] seg_for(input logic [2:0] i, input logic [31:0] data,
                                         input logic [16:0] ctrl);
    logic [7:0] blank;
    logic [7:0] dp;
    blank = ctrl[7:0];
    dp    = ctrl[15:8];
    if (blank[i]) seg_for = 8'hFF;
    else          seg_for = ~{dp[i], hex7(data[{i, 2'b00} +: 4])};
  endfunction

  function automatic logic [NUM_DIGITS-1:0] dig_for(input logic [2:0] i, input logic [16:0] ctrl);
    logic [7:0] blank;
    blank   = ctrl[7:0];
    dig_for = '1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (3'(k) == i && !blank[i]) dig_for[k] = 1'b0;
  endfunction

  // The FSM looks at register values as they will be after this edge, so a
  // bus write is visible on the display at the same edge it lands.
  always_comb begin
    wr       = chipselect & ~write_n;
    data_nxt = data_reg;
    ctrl_nxt = ctrl_reg;
    div_nxt  = div_reg;
    if (wr) begin
      case (address)
        2'd0:    data_nxt = writedata;
        2'd1:    ctrl_nxt = writedata[16:0];
        2'd2:    div_nxt  = writedata[15:0];
        default: ;
      endcase
    end
    idx_step  = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    show_load = (div_nxt == 16'd0) ? 16'd0 : div_nxt - 16'd1;
  end

  always_comb begin
    case (address)
      2'd0:    readdata = data_reg;
      2'd1:    readdata = {15'd0, ctrl_reg};
      2'd2:    readdata = {16'd0, div_reg};
      default: readdata = {27'd0, state == BLANK, state == SHOW, idx};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= 32'd0;
      ctrl_reg <= 17'd0;
      div_reg  <= DIV_RESET;
    end else begin
      data_reg <= data_nxt;
      ctrl_reg <= ctrl_nxt;
      div_reg  <= div_nxt;
    end
  end

  // Scan FSM; seg_n/dig_n are registered alongside state so that digit
  // enables can never glitch low between slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      seg_n <= 8'hFF;
      dig_n <= '1;
    end else if (!ctrl_nxt[16]) begin
      state <= IDLE;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      seg_n <= 8'hFF;
      dig_n <= '1;
    end else begin
      case (state)
        IDLE: begin
          state <= SHOW;
          cnt   <= show_load;
          idx   <= 3'd0;
          seg_n <= seg_for(3'd0, data_nxt, ctrl_nxt);
          dig_n <= dig_for(3'd0, ctrl_nxt);
        end
        SHOW: begin
          if (cnt != 16'd0) begin
            cnt   <= cnt - 16'd1;
            seg_n <= seg_for(idx, data_nxt, ctrl_nxt);
            dig_n <= dig_for(idx, ctrl_nxt);
          end else if (BLANK_CYCLES == 0) begin
            cnt   <= show_load;
            idx   <= idx_step;
            seg_n <= seg_for(idx_step, data_nxt, ctrl_nxt);
            dig_n <= dig_for(idx_step, ctrl_nxt);
          end else begin
            state <= BLANK;
            cnt   <= BLANK_LOAD;
            seg_n <= 8'hFF;
            dig_n <= '1;
          end
        end
        BLANK: begin
          if (cnt != 16'd0) begin
            cnt   <= cnt - 16'd1;
            seg_n <= 8'hFF;
            dig_n <= '1;
          end else begin
            state <= SHOW;
            cnt   <= show_load;
            idx   <= idx_step;
            seg_n <= seg_for(idx_step, data_nxt, ctrl_nxt);
            dig_n <= dig_for(idx_step, ctrl_nxt);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 16'd0;
          idx   <= 3'd0;
          seg_n <= 8'hFF;
          dig_n <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_sys_seg7_scan_ctrl.sv
// Bench for nios_sys_seg7_scan_ctrl: register vectors, hand-written scan
// sequences and random bus traffic against a slot-timing reference model.
module tb_nios_sys_seg7_scan_ctrl;

  localparam int NUM_DIGITS   = 4;
  localparam int BLANK_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  nios_sys_seg7_scan_ctrl #(
    .NUM_DIGITS(NUM_DIGITS), .BLANK_CYCLES(BLANK_CYCLES), .DIV_RESET(16'd5000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_n(seg_n), .dig_n(dig_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register copies plus position within the current digit period.
  logic [31:0] m_data;
  logic [16:0] m_ctrl;
  logic [15:0] m_div;
  bit          m_en;
  int          m_dig, m_t, m_len;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[6];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 32'd0; m_ctrl = 17'd0; m_div = 16'd5000;
    m_en = 1'b0; m_dig = 0; m_t = 0; m_len = 1;
  endtask

  task automatic model_step(input logic wr, input logic [1:0] a, input logic [31:0] wd);
    if (wr) begin
      case (a)
        2'd0: m_data = wd;
        2'd1: m_ctrl = wd[16:0];
        2'd2: m_div  = wd[15:0];
        default: ;
      endcase
    end
    if (!m_ctrl[16]) begin
      m_en = 1'b0; m_dig = 0; m_t = 0;
    end else if (!m_en) begin
      m_en = 1'b1; m_dig = 0; m_t = 0;
      m_len = (m_div == 16'd0) ? 1 : int'(m_div);
    end else begin
      m_t++;
      if (m_t == m_len + BLANK_CYCLES) begin
        m_dig = (m_dig + 1) % NUM_DIGITS;
        m_t   = 0;
        m_len = (m_div == 16'd0) ? 1 : int'(m_div);
      end
    end
  endtask

  task automatic checkOutput();
    logic [7:0]  exp_seg, blank_v, dp_v;
    logic [3:0]  exp_dig;
    logic [31:0] dsh, exp_stat;
    bit          showing;
    showing = m_en && (m_t < m_len);
    blank_v = m_ctrl[7:0] >> m_dig;
    dp_v    = m_ctrl[15:8] >> m_dig;
    dsh     = m_data >> (4 * m_dig);
    exp_seg = 8'hFF;
    exp_dig = 4'hF;
    if (showing && !blank_v[0]) begin
      exp_dig = ~(4'b0001 << m_dig);
      exp_seg = ~{dp_v[0], hex_tab[dsh[3:0]]};
    end
    check_val("seg_n", {24'd0, seg_n}, {24'd0, exp_seg});
    check_val("dig_n", {28'd0, dig_n}, {28'd0, exp_dig});
    exp_stat = {27'd0, m_en && (m_t >= m_len), showing, 3'(m_dig)};
    address = 2'd3;
    #1;
    check_val("status", readdata, exp_stat);
  endtask

  task automatic applyStimulus(input logic cs, input logic wn, input logic [1:0] a,
                               input logic [31:0] wd);
    @(negedge clk);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    model_step(cs && !wn, a, wd);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    checkOutput();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    applyStimulus(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 2'd0, 32'd0);
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check_val(name, readdata, exp);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0, n1, k;
    int low1;
    logic [1:0]  ra;
    logic [31:0] rd;

    vecs[0] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_0007, 2'd2, 32'h0000_0007};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 2'd0, 32'h1234_5678, 2'd0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 2'd1, 32'hFFFE_FF00, 2'd1, 32'h0000_FF00};
    vecs[4] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput();
    read_check("reset_data", 2'd0, 32'd0);
    read_check("reset_ctrl", 2'd1, 32'd0);
    read_check("reset_div", 2'd2, 32'd5000);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata);
      read_check($sformatf("regvec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Basic scan: 3-cycle slots, 2-cycle gaps, digits 0..3 then wrap.
    bus_write(2'd0, 32'h0000_4321);
    bus_write(2'd2, 32'd3);
    bus_write(2'd1, 32'h0001_0000);
    check_val("scan_dig0_seg", {24'd0, seg_n}, {24'd0, ~8'h06});
    for (k = 0; k < 25; k++) begin
      if (k > 0) idle(1);
      check_val($sformatf("scan_order_k%0d", k), {28'd0, dig_n},
                {28'd0, ((k % 5) < 3) ? ~(4'b0001 << ((k / 5) % 4)) : 4'hF});
    end

    // Masks: digit1 blanked, dp lit on digit0.
    bus_write(2'd1, 32'h0001_0102);
    low1 = 0;
    for (k = 0; k < 25; k++) begin
      idle(1);
      if (dig_n[1] == 1'b0) low1++;
      if (dig_n == 4'hE) check_val("mask_dp0", {31'd0, seg_n[7]}, 32'd0);
    end
    check_val("mask_dig1_never_low", low1, 0);

    // Disable while digit2 is lit, then re-enable.
    bus_write(2'd1, 32'h0001_0000);
    n0 = 0;
    for (k = 0; k < 40; k++) begin
      idle(1);
      address = 2'd3;
      #1;
      if (readdata[2:0] == 3'd2 && readdata[3]) begin
        n0 = 1;
        break;
      end
    end
    check_val("reach_idx2", n0, 1);
    bus_write(2'd1, 32'h0000_0000);
    check_val("disable_dark", {28'd0, dig_n}, 32'hF);
    read_check("disable_status", 2'd3, 32'd0);
    bus_write(2'd1, 32'h0001_0000);
    check_val("reenable_dig0", {28'd0, dig_n}, 32'hE);

    // DIV changed 3->6 during digit0's slot.
    bus_write(2'd1, 32'h0000_0000);
    bus_write(2'd2, 32'd3);
    bus_write(2'd1, 32'h0001_0000);
    n0 = (dig_n == 4'hE) ? 1 : 0;
    bus_write(2'd2, 32'd6);
    for (k = 0; k < 20 && dig_n == 4'hE; k++) begin
      n0++;
      idle(1);
    end
    check_val("div_old_slot_len", n0, 3);
    for (k = 0; k < 10 && dig_n != 4'hD; k++) idle(1);
    n1 = 0;
    for (k = 0; k < 20 && dig_n == 4'hD; k++) begin
      n1++;
      idle(1);
    end
    check_val("div_new_slot_len", n1, 6);

    // DATA nibble for digit1 rewritten mid-slot.
    for (k = 0; k < 40 && dig_n != 4'hD; k++) idle(1);
    check_val("reach_dig1", {28'd0, dig_n}, 32'hD);
    bus_write(2'd0, 32'h0000_43F1);
    check_val("data_live_seg", {24'd0, seg_n}, {24'd0, ~8'h71});
    check_val("data_live_dig", {28'd0, dig_n}, 32'hD);

    // DIV=0 behaves as single-cycle slots.
    bus_write(2'd2, 32'd0);
    idle(30);

    // Asynchronous reset while a digit is lit.
    for (k = 0; k < 20 && dig_n == 4'hF; k++) idle(1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("async_reset_seg", {24'd0, seg_n}, 32'hFF);
    check_val("async_reset_dig", {28'd0, dig_n}, 32'hF);
    read_check("async_reset_div", 2'd2, 32'd5000);
    read_check("async_reset_ctrl", 2'd1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Random bus traffic against the reference model.
    bus_write(2'd2, 32'd2);
    bus_write(2'd1, 32'h0001_0000);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        idle(1);
      end else begin
        ra = 2'($urandom_range(0, 3));
        rd = $urandom;
        if (ra == 2'd2) rd = 32'($urandom_range(0, 4));
        if (ra == 2'd1) rd[16] = ($urandom_range(0, 5) != 0);
        applyStimulus(1'b1, ($urandom_range(0, 7) == 0), ra, rd);
      end
    end
    read_check("final_data", 2'd0, m_data);
    read_check("final_ctrl", 2'd1, {15'd0, m_ctrl});
    read_check("final_div", 2'd2, {16'd0, m_div});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
